cart_loader: RTL
================

# cart_loader

Streaming cartridge-image loader that sequences the cart memories. It accepts an iNES 1.0 file as a byte stream, validates and latches the 16-byte header, skips an optional trainer, then writes PRG-ROM and CHR-ROM bytes into the PRG and CHR BRAM AXI-side ports. It holds the NES in reset while loading and publishes the `ines_header` word consumed by the mapper configuration logic.

## Interface
- PRG_WIDTH, 17: PRG BRAM byte-address width; capacity 2^PRG_WIDTH bytes.
- CHR_WIDTH, 15: CHR BRAM byte-address width; capacity 2^CHR_WIDTH bytes.

- S_AXI_ACLK  in  1  single clock for all logic.
- S_AXI_ARESETN  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle load request; honoured only in IDLE, DONE or ERR.
- s_tdata  in  8  file byte.
- s_tvalid  in  1  byte valid.
- s_tready  out  1  byte accepted when s_tvalid && s_tready.
- s_tlast  in  1  final byte of file.
- BRAM_PRG_addr  out  PRG_WIDTH  byte address; bits [1:0] always 0.
- BRAM_PRG_wr  out  32  accepted byte replicated ×4.
- BRAM_PRG_en, BRAM_PRG_we  out  1, 4  enable and one-hot byte-lane write strobe.
- BRAM_CHR_addr, BRAM_CHR_wr, BRAM_CHR_en, BRAM_CHR_we  out  CHR_WIDTH, 32, 1, 4  same rules as PRG.
- ines_header  out  64  {b11,b10,b9,b8,b7,b6,b5,b4} of the file header.
- nes_reset  out  1  console reset request.
- busy  out  1  high in any state other than IDLE, DONE, ERR.
- error  out  3  0 none, 1 bad magic, 2 truncated, 3 PRG oversize, 4 CHR oversize, 5 PRG count zero.

## Operation
- States: IDLE, HDR, TRAINER, PRG, CHR, DRAIN, DONE, ERR.
- IDLE/DONE/ERR + start → HDR. The transition clears the byte counter and error and sets nes_reset=1.
- HDR: 16 bytes.
  - Bytes 0–3 must be 4E 45 53 1A. A mismatch latches error=1 and goes to DRAIN.
  - Bytes 4–11 are latched into ines_header. Bytes 12–15 are discarded.
  - On byte 15, checked in this priority order:
    - b4==0 → error 5.
    - b4·16384 > 2^PRG_WIDTH → error 3.
    - b5·8192 > 2^CHR_WIDTH → error 4.
    - Any error goes to DRAIN. Otherwise go to TRAINER if b6[2] is set, else PRG.
- TRAINER: discard 512 bytes, then PRG.
- PRG: b4·16384 bytes, addresses 0 upward. Then CHR if b5≠0; else DONE on tlast, or DRAIN with no error.
- CHR: b5·8192 bytes, addresses 0 upward. Then DONE on tlast, else DRAIN with no error.
- Excess bytes after the image are discarded in DRAIN. DRAIN → DONE if error==0, else ERR, on the accepted tlast.
- s_tlast accepted before the last expected byte in HDR, TRAINER, PRG or CHR → error=2, ERR immediately. A pending error code keeps precedence.
- Byte write: a byte accepted at offset n produces:
  - addr = n & ~3
  - we = 1<<n[1:0]
  - wr = {4{byte}}
  - en = 1
- Counter is PRG_WIDTH+1 or CHR_WIDTH+1 bits (whichever is larger) so the full-capacity image does not wrap.
- nes_reset:
  - Stays 1 through ERR.
  - Drops to 0 on entry to DONE.
  - Is unaffected by start being ignored while busy.
- ines_header keeps its last value in ERR. Bytes are overwritten as received.

## Timing
- Reset values:
  - state IDLE, ines_header 0, nes_reset 0, busy 0, error 0.
  - s_tready 0.
  - All BRAM en/we/addr/wr 0.
- s_tready is 1 in HDR, TRAINER, PRG, CHR, DRAIN and 0 elsewhere. It never depends combinationally on s_tvalid.
- Throughput: one byte per cycle, sustained.
- BRAM writes are registered: a byte accepted in cycle N drives en/we/addr/wr in cycle N+1 for exactly one cycle. Otherwise en=0 and we=0.
- Completion: busy falls and nes_reset falls in the cycle after the final accepted byte. The final BRAM write is visible in that same cycle.
- start coincident with an accepted byte in DONE/ERR: start wins, and that byte is not accepted (s_tready=0 in those states).
- Reset asserted mid-load: immediate return to reset values. Partial BRAM contents are left as written.

## Test plan
- Valid NROM image (b4=1, b5=1, b6=01, b7=00), no gaps, PRG_WIDTH=17:
  - 16384 PRG writes, last at addr 0x3FFC we=1000.
  - 8192 CHR writes.
  - ines_header=0x0000_0000_0001_0101.
  - done one cycle after tlast, nes_reset falls.
- Trainer flag b6=04, random s_tvalid gaps:
  - 512 bytes produce no writes.
  - First PRG write carries file byte 528 at addr 0.
- Magic byte 3 = 0x1B:
  - error=1, no BRAM writes, s_tready high until tlast.
  - Then ERR, with nes_reset still 1.
- b4=16 with PRG_WIDTH=17:
  - error=3 after byte 15, drain, ERR.
  - Repeat with b5=8 and CHR_WIDTH=15 → error=4.
- tlast on PRG byte 100 of 16384 → error=2, ERR next cycle, s_tready=0.
- CHR-RAM image (b5=0) followed by 10 padding bytes:
  - Padding is drained without writes.
  - DONE with error 0.
- Reset deasserted then reasserted mid-PRG → all outputs return to reset values.
- start pulsed while busy → no effect.

Source files
------------

// File: rtl/cart_loader.sv
// Streams an iNES 1.0 image into the PRG/CHR BRAM ports, latching the header
// and holding the console in reset while the cartridge memories are loaded.
module cart_loader #(
   parameter int PRG_WIDTH = 17,
   parameter int CHR_WIDTH = 15
) (
   input  logic                 S_AXI_ACLK,
   input  logic                 S_AXI_ARESETN,
   input  logic                 start,
   input  logic [7:0]           s_tdata,
   input  logic                 s_tvalid,
   output logic                 s_tready,
   input  logic                 s_tlast,
   output logic [PRG_WIDTH-1:0] BRAM_PRG_addr,
   output logic [31:0]          BRAM_PRG_wr,
   output logic                 BRAM_PRG_en,
   output logic [3:0]           BRAM_PRG_we,
   output logic [CHR_WIDTH-1:0] BRAM_CHR_addr,
   output logic [31:0]          BRAM_CHR_wr,
   output logic                 BRAM_CHR_en,
   output logic [3:0]           BRAM_CHR_we,
   output logic [63:0]          ines_header,
   output logic                 nes_reset,
   output logic                 busy,
   output logic [2:0]           error
);
   // One extra bit so a full-capacity section count does not wrap.
   localparam int CW = ((PRG_WIDTH > CHR_WIDTH) ? PRG_WIDTH : CHR_WIDTH) + 1;
   localparam logic [31:0]   PRG_CAP = 32'd1 << PRG_WIDTH;
   localparam logic [31:0]   CHR_CAP = 32'd1 << CHR_WIDTH;
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   localparam logic [2:0] ERR_NONE     = 3'd0;
   localparam logic [2:0] ERR_MAGIC    = 3'd1;
   localparam logic [2:0] ERR_TRUNC    = 3'd2;
   localparam logic [2:0] ERR_PRG_SIZE = 3'd3;
   localparam logic [2:0] ERR_CHR_SIZE = 3'd4;
   localparam logic [2:0] ERR_PRG_ZERO = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE, S_HDR, S_TRAINER, S_PRG, S_CHR, S_DRAIN, S_DONE, S_ERR
   } state_t;

   state_t          state_reg, state_next;
   logic [CW-1:0]   cnt_reg, cnt_next;
   logic [2:0]      error_reg, error_next;
   logic            nes_reset_reg, nes_reset_next;
   logic [63:0]     header_reg;
   logic            accept, hdr_latch, prg_write, chr_write, early_last;
   logic [31:0]     cnt_ext, prg_bytes, chr_bytes;
   logic            prg_last, chr_last, magic_ok;
   logic [7:0]      magic_byte;
   logic [2:0]      hdr_idx;

   assign s_tready = (state_reg == S_HDR) || (state_reg == S_TRAINER) ||
                     (state_reg == S_PRG) || (state_reg == S_CHR) || (state_reg == S_DRAIN);
   assign busy     = !((state_reg == S_IDLE) || (state_reg == S_DONE) || (state_reg == S_ERR));
   assign accept   = s_tvalid && s_tready;

   assign cnt_ext   = 32'(cnt_reg);
   assign prg_bytes = {10'd0, header_reg[7:0], 14'd0};
   assign chr_bytes = {11'd0, header_reg[15:8], 13'd0};
   assign prg_last  = (cnt_ext == prg_bytes - 32'd1);
   assign chr_last  = (cnt_ext == chr_bytes - 32'd1);
   assign hdr_idx   = cnt_reg[2:0] - 3'd4;

   always_comb begin
      case (cnt_reg[1:0])
         2'd0:    magic_byte = 8'h4E;
         2'd1:    magic_byte = 8'h45;
         2'd2:    magic_byte = 8'h53;
         default: magic_byte = 8'h1A;
      endcase
   end
   assign magic_ok = (s_tdata == magic_byte);

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) state_reg <= S_IDLE;
      else                state_reg <= state_next;
   end

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      error_next     = error_reg;
      nes_reset_next = nes_reset_reg;
      hdr_latch      = 1'b0;
      prg_write      = 1'b0;
      chr_write      = 1'b0;
      early_last     = 1'b0;
      case (state_reg)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_next     = S_HDR;
               cnt_next       = '0;
               error_next     = ERR_NONE;
               nes_reset_next = 1'b1;
            end
         end
         S_HDR: begin
            if (accept) begin
               cnt_next   = cnt_reg + CNT_ONE;
               hdr_latch  = (cnt_reg >= CW'(4)) && (cnt_reg <= CW'(11));
               early_last = s_tlast;
               if ((cnt_reg < CW'(4)) && !magic_ok) begin
                  error_next = ERR_MAGIC;
                  state_next = S_DRAIN;
               end else if (cnt_reg == CW'(15)) begin
                  cnt_next = '0;
                  if (header_reg[7:0] == 8'd0)  error_next = ERR_PRG_ZERO;
                  else if (prg_bytes > PRG_CAP) error_next = ERR_PRG_SIZE;
                  else if (chr_bytes > CHR_CAP) error_next = ERR_CHR_SIZE;
                  if (error_next != ERR_NONE) state_next = S_DRAIN;
                  else if (header_reg[18])    state_next = S_TRAINER;
                  else                        state_next = S_PRG;
               end
            end
         end
         S_TRAINER: begin
            if (accept) begin
               cnt_next   = cnt_reg + CNT_ONE;
               early_last = s_tlast;
               if (cnt_reg == CW'(511)) begin
                  cnt_next   = '0;
                  state_next = S_PRG;
               end
            end
         end
         S_PRG: begin
            if (accept) begin
               prg_write = 1'b1;
               cnt_next  = cnt_reg + CNT_ONE;
               if (prg_last) begin
                  cnt_next = '0;
                  if (header_reg[15:8] != 8'd0) begin
                     state_next = S_CHR;
                     early_last = s_tlast;
                  end else if (s_tlast) begin
                     state_next     = S_DONE;
                     nes_reset_next = 1'b0;
                  end else begin
                     state_next = S_DRAIN;
                  end
               end else begin
                  early_last = s_tlast;
               end
            end
         end
         S_CHR: begin
            if (accept) begin
               chr_write = 1'b1;
               cnt_next  = cnt_reg + CNT_ONE;
               if (chr_last) begin
                  cnt_next = '0;
                  if (s_tlast) begin
                     state_next     = S_DONE;
                     nes_reset_next = 1'b0;
                  end else begin
                     state_next = S_DRAIN;
                  end
               end else begin
                  early_last = s_tlast;
               end
            end
         end
         S_DRAIN: begin
            if (accept && s_tlast) begin
               if (error_reg == ERR_NONE) begin
                  state_next     = S_DONE;
                  nes_reset_next = 1'b0;
               end else begin
                  state_next = S_ERR;
               end
            end
         end
         default: state_next = S_IDLE;
      endcase
      // A stream that ends early aborts; an error already found keeps its code.
      if (early_last) begin
         state_next = S_ERR;
         if (error_next == ERR_NONE) error_next = ERR_TRUNC;
      end
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         cnt_reg       <= '0;
         error_reg     <= ERR_NONE;
         nes_reset_reg <= 1'b0;
         header_reg    <= '0;
         BRAM_PRG_addr <= '0;
         BRAM_PRG_wr   <= '0;
         BRAM_PRG_en   <= 1'b0;
         BRAM_PRG_we   <= '0;
         BRAM_CHR_addr <= '0;
         BRAM_CHR_wr   <= '0;
         BRAM_CHR_en   <= 1'b0;
         BRAM_CHR_we   <= '0;
      end else begin
         cnt_reg       <= cnt_next;
         error_reg     <= error_next;
         nes_reset_reg <= nes_reset_next;
         if (hdr_latch) header_reg[{hdr_idx, 3'b000} +: 8] <= s_tdata;
         BRAM_PRG_en <= prg_write;
         BRAM_PRG_we <= prg_write ? (4'b0001 << cnt_reg[1:0]) : 4'b0000;
         if (prg_write) begin
            BRAM_PRG_addr <= {cnt_reg[PRG_WIDTH-1:2], 2'b00};
            BRAM_PRG_wr   <= {4{s_tdata}};
         end
         BRAM_CHR_en <= chr_write;
         BRAM_CHR_we <= chr_write ? (4'b0001 << cnt_reg[1:0]) : 4'b0000;
         if (chr_write) begin
            BRAM_CHR_addr <= {cnt_reg[CHR_WIDTH-1:2], 2'b00};
            BRAM_CHR_wr   <= {4{s_tdata}};
         end
      end
   end

   assign ines_header = header_reg;
   assign nes_reset   = nes_reset_reg;
   assign error       = error_reg;
endmodule
